// File: rtl/fb_write_arb.sv
// Round-robin arbiter for the framebuffer write port with burst locking and a
// 2-stage y*FB_WIDTH+x address pipeline. Optional bounds clipping: FB_WRITE_ARB_CLIP_EN.
module fb_write_arb #(
  parameter int NREQ      = 2,
  parameter int CORDW     = 9,
  parameter int DATAW     = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDRW     = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*CORDW-1:0]    req_x,
  input  logic [NREQ*CORDW-1:0]    req_y,
  input  logic [NREQ*DATAW-1:0]    req_cidx,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fb_we,
  output logic [ADDRW-1:0]         fb_addr,
  output logic [DATAW-1:0]         fb_cidx,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     locked
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   grant_q;
  logic             locked_q;

  logic [IDW-1:0]   win_id;
  logic             win_any;
  logic [IDW-1:0]   acc_id;
  logic             accept;
  logic             acc_last;
  logic [CORDW-1:0] acc_x;
  logic [CORDW-1:0] acc_y;
  logic [DATAW-1:0] acc_cidx;
  logic             acc_inb;

  logic             vld_p1;
  logic [ADDRW-1:0] base_p1;
  logic [CORDW-1:0] x_p1;
  logic [DATAW-1:0] cidx_p1;

  logic             fb_we_q;
  logic [ADDRW-1:0] fb_addr_q;
  logic [DATAW-1:0] fb_cidx_q;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) == NREQ - 1) return '0;
    return id + 1'b1;
  endfunction

  function automatic logic [ADDRW-1:0] row_base(input logic [CORDW-1:0] y);
    return ADDRW'(y) * ADDRW'(FB_WIDTH);
  endfunction

  function automatic logic [ADDRW-1:0] lin_addr(input logic [ADDRW-1:0] base,
                                                input logic [CORDW-1:0] x);
    return base + ADDRW'(x);
  endfunction

  // Scan downwards so the lowest offset from rr is the one left standing.
  always_comb begin
    int idx;
    idx     = 0;
    win_id  = '0;
    win_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[IDW'(idx)]) begin
        win_id  = IDW'(idx);
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    acc_id    = win_id;
    if (state_q == LOCKED) begin
      req_ready[owner_q] = 1'b1;
      acc_id             = owner_q;
    end else if (win_any) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign accept   = req_valid[acc_id] & req_ready[acc_id];
  assign acc_last = req_last[acc_id];
  assign acc_x    = req_x[int'(acc_id)*CORDW +: CORDW];
  assign acc_y    = req_y[int'(acc_id)*CORDW +: CORDW];
  assign acc_cidx = req_cidx[int'(acc_id)*DATAW +: DATAW];

`ifdef FB_WRITE_ARB_CLIP_EN
  assign acc_inb = (32'(acc_x) < FB_WIDTH) && (32'(acc_y) < FB_HEIGHT);
`else
  assign acc_inb = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
    end else if (accept) begin
      grant_q <= acc_id;
      case (state_q)
        IDLE: begin
          if (acc_last) begin
            rr_q <= next_id(acc_id);
          end else begin
            state_q  <= LOCKED;
            owner_q  <= acc_id;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (acc_last) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            rr_q     <= next_id(owner_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1: row base product, x and colour
  always_ff @(posedge clk) begin
    if (accept) begin
      base_p1 <= row_base(acc_y);
      x_p1    <= acc_x;
      cidx_p1 <= acc_cidx;
    end
  end

  // Stage 2: final address and write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_cidx_q <= '0;
    end else begin
      vld_p1  <= accept & acc_inb;
      fb_we_q <= vld_p1;
      if (vld_p1) begin
        fb_addr_q <= lin_addr(base_p1, x_p1);
        fb_cidx_q <= cidx_p1;
      end
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_cidx  = fb_cidx_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_fb_write_arb.sv
// Bench for fb_write_arb: directed scenarios plus random traffic against a
// transaction-level arbitration/write model.
module tb_fb_write_arb;

  localparam int NREQ = 2, CORDW = 9, DATAW = 4;
  localparam int FB_WIDTH = 320, FB_HEIGHT = 240, ADDRW = 17;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid, req_last, req_ready;
  logic [NREQ*CORDW-1:0]   req_x, req_y;
  logic [NREQ*DATAW-1:0]   req_cidx;
  logic                    fb_we, locked;
  logic [ADDRW-1:0]        fb_addr;
  logic [DATAW-1:0]        fb_cidx;
  logic [$clog2(NREQ)-1:0] grant_id;

  int checks = 0;
  int failures = 0;

  // Model state
  int m_owner, m_rr, m_gid, m_addr, m_cidx, m_p1a, m_p1c;
  bit m_locked, m_we, m_p1v;

  always #5 clk = ~clk;

  fb_write_arb #(.NREQ(NREQ), .CORDW(CORDW), .DATAW(DATAW), .FB_WIDTH(FB_WIDTH),
                 .FB_HEIGHT(FB_HEIGHT), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_cidx(req_cidx), .req_ready(req_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_cidx(fb_cidx),
    .grant_id(grant_id), .locked(locked));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input int x, input int y,
                         input int c);
    req_valid[i] = v;
    req_last[i]  = l;
    req_x[i*CORDW +: CORDW]    = CORDW'(x);
    req_y[i*CORDW +: CORDW]    = CORDW'(y);
    req_cidx[i*DATAW +: DATAW] = DATAW'(c);
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_gid = 0; m_locked = 0;
    m_we = 0; m_addr = 0; m_cidx = 0; m_p1v = 0; m_p1a = 0; m_p1c = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic [NREQ-1:0] er;
    int w, x, y;
    bit found, acc, inb;
    @(negedge clk);
    er = '0; w = 0; found = 0;
    if (m_owner >= 0) begin
      er[m_owner] = 1'b1; w = m_owner; found = 1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (!found && req_valid[i]) begin er[i] = 1'b1; w = i; found = 1; end
      end
    end
    chk("ready", 32'(req_ready), 32'(er));
    chk("fb_we", 32'(fb_we), 32'(m_we));
    chk("fb_addr", 32'(fb_addr), 32'(m_addr));
    chk("fb_cidx", 32'(fb_cidx), 32'(m_cidx));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("locked", 32'(locked), 32'(m_locked));
    acc = found && req_valid[w];
    x = int'(req_x[w*CORDW +: CORDW]);
    y = int'(req_y[w*CORDW +: CORDW]);
`ifdef FB_WRITE_ARB_CLIP_EN
    inb = (x < FB_WIDTH) && (y < FB_HEIGHT);
`else
    inb = 1;
`endif
    if (rst) begin
      model_reset();
    end else begin
      m_we = m_p1v;
      if (m_p1v) begin m_addr = m_p1a; m_cidx = m_p1c; end
      m_p1v = acc && inb;
      if (acc) begin
        m_p1a = (y * FB_WIDTH + x) % (1 << ADDRW);
        m_p1c = int'(req_cidx[w*DATAW +: DATAW]);
        m_gid = w;
        if (m_owner < 0) begin
          if (req_last[w]) m_rr = (w + 1) % NREQ;
          else begin m_owner = w; m_locked = 1; end
        end else if (req_last[w]) begin
          m_owner = -1; m_locked = 0; m_rr = (w + 1) % NREQ;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_cidx = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_cidx", 32'(fb_cidx), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    rst = 1'b0;
    repeat (5) step();

    // Single beat
    set_req(0, 1, 1, 5, 2, 9);
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("t1_we", 32'(fb_we), 1);
    chk("t1_addr", 32'(fb_addr), 645);
    chk("t1_cidx", 32'(fb_cidx), 9);
    chk("t1_locked", 32'(locked), 0);

    // Alternating single beats; rr is 1 after the previous grant to req0
    for (int k = 0; k < 7; k++) begin
      set_req(0, 1, 1, k, 1, k);
      set_req(1, 1, 1, k + 100, 7, k + 3);
      step();
      chk("t2_gnt", 32'(grant_id), 32'((k + 1) % 2));
      if (k >= 1) chk("t2_we", 32'(fb_we), 1);
    end

    // req0 burst of 4 with req1 pending
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1, b == 3, 10 + b, 3, b + 1);
      set_req(1, 1, 1, 50, 50, 15);
      #1 chk("t3_ready", 32'(req_ready), 32'h1);
      step();
      if (b < 3) chk("t3_locked", 32'(locked), 1);
    end
    chk("t3_unlock", 32'(locked), 0);
    set_req(0, 0, 0, 0, 0, 0);
    #1 chk("t3_req1", 32'(req_ready), 32'h2);
    step();

    // Burst with a 3-cycle gap while req1 waits
    set_req(0, 1, 0, 20, 4, 6);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) begin
      #1 chk("t4_hold", 32'(req_ready), 32'h1);
      step();
    end
    chk("t4_gap_we", 32'(fb_we), 0);
    set_req(0, 1, 1, 21, 4, 7);
    step();
    chk("t4_unlock", 32'(locked), 0);
    set_req(0, 0, 0, 0, 0, 0);
    #1 chk("t4_req1", 32'(req_ready), 32'h2);
    step();

    // Reset one cycle after a mid-burst req1 beat
    set_req(1, 1, 0, 30, 8, 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_we", 32'(fb_we), 0);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_gid", 32'(grant_id), 0);
    set_req(0, 1, 1, 1, 1, 1);
    set_req(1, 1, 1, 2, 2, 2);
    #1 chk("t5_scan", 32'(req_ready), 32'h1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();

`ifdef FB_WRITE_ARB_CLIP_EN
    set_req(0, 1, 1, 320, 0, 5);
    #1 chk("clip_ready", 32'(req_ready), 32'h1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("clip_we", 32'(fb_we), 0);
`endif
    set_req(0, 1, 1, 319, 239, 7);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("corner_we", 32'(fb_we), 1);
    chk("corner_addr", 32'(fb_addr), 76799);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
`ifdef FB_WRITE_ARB_CLIP_EN
        set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                $urandom_range(0, 350), $urandom_range(0, 260), $urandom_range(0, 15));
`else
        set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                $urandom_range(0, FB_WIDTH - 1), $urandom_range(0, FB_HEIGHT - 1),
                $urandom_range(0, 15));
`endif
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_arb.md
Name: fb_write_arb

Overview:
- Arbitrates the single framebuffer BRAM write port between NREQ drawing engines (triangle, line, clear/fill, ...).
- Each engine presents pixel coordinates plus a colour index on a valid/ready handshake.
- Grants are round-robin, held per shape burst (until req_last), so a shape is never interleaved with another engine's pixels.
- Computes the linear address y*FB_WIDTH+x in a 2-stage pipeline and drives the framebuffer write port directly, replacing the per-engine pix_addr and fb_we glue in top-level designs.

Parameters:
- NREQ, 2, number of requesters (>=2)
- CORDW, 9, coordinate width in bits
- DATAW, 4, colour index width
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- ADDRW, 17, framebuffer address width (>= $clog2(FB_WIDTH*FB_HEIGHT))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- req_valid  in  NREQ  requester i has a pixel beat
- req_last  in  NREQ  beat is the final pixel of requester i's shape
- req_x  in  NREQ*CORDW  x coordinate; requester i at bits [i*CORDW +: CORDW]
- req_y  in  NREQ*CORDW  y coordinate, same packing
- req_cidx  in  NREQ*DATAW  colour index, packed likewise
- req_ready  out  NREQ  beat of requester i accepted this cycle when valid&ready
- fb_we  out  1  framebuffer write enable
- fb_addr  out  ADDRW  framebuffer write address
- fb_cidx  out  DATAW  framebuffer write data
- grant_id  out  $clog2(NREQ)  current/last granted requester (registered)
- locked  out  1  a burst is in progress (registered)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - fb_we=0, fb_addr=0, fb_cidx=0, grant_id=0, locked=0.
  - Round-robin pointer rr=0; state IDLE; both pipeline valid bits cleared.
- req_ready is combinational from the state, rr, owner and req_valid; no other output is combinational.
- States:
  - IDLE, no owner:
    - Winner = first i with req_valid[i], scanning rr, rr+1, ... modulo NREQ.
    - req_ready[winner]=1, all others 0. If no valid, all ready=0.
    - Winner beat accepted with req_last=1: stay IDLE, rr<=winner+1 (mod NREQ).
    - Winner beat accepted with req_last=0: go LOCKED, owner<=winner, locked<=1.
    - grant_id<=winner on any accepted beat.
  - LOCKED:
    - req_ready[owner]=1 every cycle (valid or not); all others 0.
    - Owner may deassert valid mid-burst; the lock is held through gaps.
    - Owner beat with req_last=1: go IDLE, locked<=0, rr<=owner+1.
- Throughput: one beat per cycle. Back-to-back bursts from different requesters have no bubble; the cycle after a last beat arbitrates in IDLE.
- Pipeline, beat accepted at cycle N:
  - N+1: stage 1 registers y*FB_WIDTH (ADDRW-wide product), x and cidx.
  - N+2: fb_we=1, fb_addr=product+x (truncated to ADDRW), fb_cidx=cidx.
  - When no beat is accepted, fb_we=0 two cycles later; fb_addr and fb_cidx hold their last values.
- Mid-burst rst: the pipeline is flushed. fb_we=0 on the next cycle, and beats accepted in the prior 2 cycles are discarded.
- Widths: all multiply and add arithmetic is ADDRW-wide, unsigned.

Optional Feature:
- Macro FB_WRITE_ARB_CLIP_EN.
- Defined:
  - Beats with x>=FB_WIDTH or y>=FB_HEIGHT are still accepted (ready unaffected) but produce fb_we=0 at N+2.
  - A clipped beat carrying req_last still ends the burst.
- Undefined: no bounds check. The address is computed and written as-is; callers guarantee in-range coordinates.

Test Plan:
- Single beat, req0 x=5 y=2 cidx=9 last=1 at cycle 10 -> req_ready[0]=1 cycle 10; fb_we=1, fb_addr=645, fb_cidx=9 at cycle 12; locked stays 0.
- Both valid continuously, all single-beat (last=1), rr=0 -> grants alternate 0,1,0,1; fb_we high every cycle from 2 cycles after the first beat.
- req0 burst of 4 beats (last on 4th) with req1 valid throughout -> req_ready[1]=0 for all 4 cycles and locked=1 after beat 1; req1 granted the cycle after req0's last beat.
- req0 burst with a 3-cycle valid gap mid-burst while req1 valid -> req1 never granted until req0's last beat; fb_we=0 during the gap (delayed by 2).
- rst asserted one cycle after a req1 beat mid-burst -> fb_we=0 next cycle; locked=0, grant_id=0; the next winner scan starts at req0.
- With FB_WRITE_ARB_CLIP_EN: req0 x=320 y=0 last=1 -> ready=1 but fb_we stays 0; req0 x=319 y=239 -> fb_addr=76799 written.
